// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller: all-red clearance, ped walk with green truncation,
// night flashing-yellow mode. All durations are in clk cycles.
module traffic_intersection_ctrl #(
  parameter int CNT_W       = 8,
  parameter int GREEN_TIME  = 60,
  parameter int MIN_GREEN   = 20,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int PED_TIME    = 10,
  parameter int FLASH_HALF  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic       night_mode,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AR_TO_NS  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    AR_TO_EW  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);
  // One extra bit so PED_TIME == 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0]   PED_LEN     = (CNT_W + 1)'(PED_TIME);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_ns_q, pend_ns_d;
  logic               pend_ew_q, pend_ew_d;
  logic               walk_arm_ns_q, walk_arm_ns_d;
  logic               walk_arm_ew_q, walk_arm_ew_d;
  logic               flash_ph_q, flash_ph_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    pend_ns_d     = pend_ns_q | ped_req_ns;
    pend_ew_d     = pend_ew_q | ped_req_ew;
    walk_arm_ns_d = walk_arm_ns_q;
    walk_arm_ew_d = walk_arm_ew_q;
    flash_ph_d    = flash_ph_q;
    case (state_q)
      AR_TO_NS: if (cnt_q == ALLRED_LAST) begin
        cnt_d = '0;
        if (night_mode) begin
          state_d    = FLASH;
          flash_ph_d = 1'b1;
        end else begin
          state_d       = NS_GREEN;
          walk_arm_ns_d = pend_ns_q | ped_req_ns;
          pend_ns_d     = ped_req_ns;   // a request on the clear cycle survives
        end
      end
      NS_GREEN: if (cnt_q == GREEN_LAST || (pend_ew_q && cnt_q >= MIN_LAST)) begin
        state_d       = NS_YELLOW;
        cnt_d         = '0;
        walk_arm_ns_d = 1'b0;
      end
      NS_YELLOW: if (cnt_q == YELLOW_LAST) begin
        state_d = AR_TO_EW;
        cnt_d   = '0;
      end
      AR_TO_EW: if (cnt_q == ALLRED_LAST) begin
        cnt_d = '0;
        if (night_mode) begin
          state_d    = FLASH;
          flash_ph_d = 1'b1;
        end else begin
          state_d       = EW_GREEN;
          walk_arm_ew_d = pend_ew_q | ped_req_ew;
          pend_ew_d     = ped_req_ew;
        end
      end
      EW_GREEN: if (cnt_q == GREEN_LAST || (pend_ns_q && cnt_q >= MIN_LAST)) begin
        state_d       = EW_YELLOW;
        cnt_d         = '0;
        walk_arm_ew_d = 1'b0;
      end
      EW_YELLOW: if (cnt_q == YELLOW_LAST) begin
        state_d = AR_TO_NS;
        cnt_d   = '0;
      end
      FLASH: begin
        if (!night_mode) begin
          state_d    = AR_TO_NS;
          cnt_d      = '0;
          flash_ph_d = 1'b0;
        end else if (cnt_q == FLASH_LAST) begin
          flash_ph_d = ~flash_ph_q;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d = AR_TO_NS;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= AR_TO_NS;
      cnt_q         <= '0;
      pend_ns_q     <= 1'b0;
      pend_ew_q     <= 1'b0;
      walk_arm_ns_q <= 1'b0;
      walk_arm_ew_q <= 1'b0;
      flash_ph_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_ns_q     <= pend_ns_d;
      pend_ew_q     <= pend_ew_d;
      walk_arm_ns_q <= walk_arm_ns_d;
      walk_arm_ew_q <= walk_arm_ew_d;
      flash_ph_q    <= flash_ph_d;
    end
  end

  always_comb begin
    ns_red    = 1'b0;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b0;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk_ns   = 1'b0;
    walk_ew   = 1'b0;
    phase     = state_q;
    case (state_q)
      NS_GREEN: begin
        ns_green = 1'b1;
        ew_red   = 1'b1;
        walk_ns  = walk_arm_ns_q && ({1'b0, cnt_q} < PED_LEN);
      end
      NS_YELLOW: begin
        ns_yellow = 1'b1;
        ew_red    = 1'b1;
      end
      EW_GREEN: begin
        ew_green = 1'b1;
        ns_red   = 1'b1;
        walk_ew  = walk_arm_ew_q && ({1'b0, cnt_q} < PED_LEN);
      end
      EW_YELLOW: begin
        ew_yellow = 1'b1;
        ns_red    = 1'b1;
      end
      FLASH: begin
        ns_yellow = flash_ph_q;
        ew_yellow = flash_ph_q;
      end
      default: begin
        ns_red = 1'b1;
        ew_red = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench: table of phase records (duration, ped pulses, night level, walk)
// plus hand-written flash and mid-phase reset sequences.
module tb_traffic_intersection_ctrl;

  localparam int PED = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ped_req_ns, ped_req_ew, night_mode;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic       walk_ns, walk_ew;
  logic [2:0] phase;

  int tests = 0;
  int fails = 0;

  traffic_intersection_ctrl #(
    .CNT_W(8), .GREEN_TIME(10), .MIN_GREEN(4), .YELLOW_TIME(3),
    .ALLRED_TIME(2), .PED_TIME(PED), .FLASH_HALF(2)
  ) dut (
    .clk(clk), .rst(rst),
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew), .night_mode(night_mode),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int dur;
    int ns_at;
    int ew_at;
    bit night;
    bit walk;
    bit pchk;
    bit pns;
    bit pew;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int ph, int dur, int ns_at = -1, int ew_at = -1,
                              bit night = 0, bit walk = 0, bit pchk = 0,
                              bit pns = 0, bit pew = 0);
    vec_t v;
    v.ph = ph; v.dur = dur; v.ns_at = ns_at; v.ew_at = ew_at; v.night = night;
    v.walk = walk; v.pchk = pchk; v.pns = pns; v.pew = pew;
    tbl.push_back(v);
  endfunction

  // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  function automatic logic [5:0] lamp_model(int ph);
    case (ph)
      1:       return 6'b001_100;
      2:       return 6'b010_100;
      4:       return 6'b100_001;
      5:       return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic logic [5:0] lamps();
    return {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_phase(input vec_t v, input int idx);
    int n;
    string tag;
    tag = $sformatf("vec%0d", idx);
    night_mode = v.night;
    chk({tag, " phase"}, int'(phase), v.ph);
    if (v.pchk) begin
      chk({tag, " pend_ns"}, int'(dut.pend_ns_q), int'(v.pns));
      chk({tag, " pend_ew"}, int'(dut.pend_ew_q), int'(v.pew));
    end
    n = 0;
    while (int'(phase) == v.ph && n < 200) begin
      chk({tag, " lamps"}, int'(lamps()), int'(lamp_model(v.ph)));
      chk({tag, " walk_ns"}, int'(walk_ns), int'(v.walk && v.ph == 1 && n < PED));
      chk({tag, " walk_ew"}, int'(walk_ew), int'(v.walk && v.ph == 4 && n < PED));
      ped_req_ns = (n == v.ns_at);
      ped_req_ew = (n == v.ew_at);
      tick();
      n++;
    end
    ped_req_ns = 1'b0;
    ped_req_ew = 1'b0;
    chk({tag, " duration"}, n, v.dur);
  endtask

  int seg_a, seg_b;
  bit exp_y;

  initial begin
    rst = 1'b1; ped_req_ns = 1'b0; ped_req_ew = 1'b0; night_mode = 1'b0;

    // free-running cycle, period 30
    add(0, 2); add(1, 10); add(2, 3); add(3, 2); add(4, 10); add(5, 3);
    // EW request during NS green cycle 1 -> truncated at MIN_GREEN
    add(0, 2); add(1, 4, -1, 1); add(2, 3); add(3, 2);
    add(4, 10, -1, -1, 0, 1); add(5, 3, -1, -1, 0, 0, 1, 0, 0);
    // EW request at cnt 7 -> one cycle latency, green lasts 9
    add(0, 2); add(1, 9, -1, 7); add(2, 3); add(3, 2);
    add(4, 10, -1, -1, 0, 1); add(5, 3);
    // NS request on the AR_TO_NS -> NS_GREEN edge: walk and pend both set
    add(0, 2, 1); add(1, 10, -1, -1, 0, 1, 1, 1, 0); add(2, 3); add(3, 2);
    add(4, 4); add(5, 3); add(0, 2);
    add(1, 10, -1, -1, 0, 1, 1, 0, 0); add(2, 3); add(3, 2);
    // night raised mid EW green: completes sequence to AR_TO_NS exit
    add(4, 10, -1, -1, 1); add(5, 3, -1, -1, 1); add(0, 2, -1, -1, 1);
    seg_a = tbl.size();
    add(0, 2); add(1, 10); add(2, 3); add(3, 2); add(4, 10, 8);
    seg_b = tbl.size();
    add(0, 2); add(1, 10);

    tick(); tick();
    chk("reset phase", int'(phase), 0);
    chk("reset lamps", int'(lamps()), int'(6'b100_100));
    chk("reset walks", int'({walk_ns, walk_ew}), 0);
    rst = 1'b0;

    for (int i = 0; i < seg_a; i++) run_phase(tbl[i], i);

    for (int k = 0; k < 6; k++) begin
      exp_y = (k % 4) < 2;
      chk($sformatf("flash%0d phase", k), int'(phase), 6);
      chk($sformatf("flash%0d lamps", k), int'(lamps()), int'({1'b0, exp_y, 2'b00, exp_y, 1'b0}));
      chk($sformatf("flash%0d walks", k), int'({walk_ns, walk_ew}), 0);
      tick();
    end
    chk("flash before exit", int'(phase), 6);
    night_mode = 1'b0;
    tick();

    for (int i = seg_a; i < seg_b; i++) run_phase(tbl[i], i);

    tick();
    chk("pre-reset phase", int'(phase), 5);
    chk("pre-reset pend_ns", int'(dut.pend_ns_q), 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset phase", int'(phase), 0);
    chk("async reset lamps", int'(lamps()), int'(6'b100_100));
    chk("async reset walks", int'({walk_ns, walk_ew}), 0);
    chk("async reset pend_ns", int'(dut.pend_ns_q), 0);
    tick();
    rst = 1'b0;

    for (int i = seg_b; i < tbl.size(); i++) run_phase(tbl[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
